seg_display_ctrl: RTL
=====================

SEG_DISPLAY_CTRL -- requirements
Module: seg_display_ctrl

Interface
REQ-001 SHALL have parameter NUM_DIGITS, default 4, legal range 1..8: number of multiplexed 7-segment digits.
REQ-002 SHALL have parameter VALUE_W, default 16, legal range 1..32: binary input width.
REQ-003 SHALL have parameter REFRESH_BITS, default 16, legal range 1..24: each digit is lit for 2^REFRESH_BITS clk cycles.
REQ-004 SHALL have port clk  in  1  system clock, at least 25 MHz.
REQ-005 SHALL have port rst  in  1  reset; one clock, reset asynchronous and active-high.
REQ-006 SHALL have port value_in  in  VALUE_W  unsigned value to display.
REQ-007 SHALL have port load  in  1  capture request; accepted when load && ready at a clk edge.
REQ-008 SHALL have port ready  out  1  high when a load can be accepted.
REQ-009 SHALL have port dec_mode  in  1  1 = decimal (BCD) display, 0 = hex display; sampled with load.
REQ-010 SHALL have port blank_lz  in  1  1 = blank leading zeros; live input.
REQ-011 SHALL have port dp_sel  in  NUM_DIGITS  bit i lights the decimal point of digit i; live input.
REQ-012 SHALL have port display_en  in  1  0 = all digits dark; live input.
REQ-013 SHALL have port seg  out  7  segments, active low, bit0 = top, bit6 = middle.
REQ-014 SHALL have port dp  out  1  decimal point, active low.
REQ-015 SHALL have port an  out  NUM_DIGITS  digit anodes, active low; bit0 = rightmost digit.
REQ-016 SHALL have port overflow  out  1  the last accepted value did not fit in NUM_DIGITS digits.

Function
REQ-017 SHALL implement the FSM IDLE -> CONV -> DONE -> IDLE; ready = 1 only in IDLE.
REQ-018 Hex accept at edge T: SHALL stay in IDLE; the display register takes the low 4*NUM_DIGITS bits at edge T+1; ready stays 1.
REQ-019 Hex overflow: if any bit of value_in above 4*NUM_DIGITS is 1, all digits SHALL show F and overflow SHALL be 1.
REQ-020 Decimal accept at edge T: SHALL run a shift-add-3 conversion in CONV over edges T+1..T+VALUE_W, go to DONE, then update the display register and return to IDLE at edge T+VALUE_W+1.
REQ-021 Decimal mode SHALL hold ready low for exactly VALUE_W+1 cycles.
REQ-022 Decimal overflow: if any 1 bit is shifted out of the top BCD digit, all digits SHALL show 9 and overflow SHALL be 1.
REQ-023 overflow SHALL update in the same cycle as the display register and otherwise hold its value.
REQ-024 load while ready = 0 SHALL be ignored, with no queuing; the value and mode latched at acceptance SHALL be used even if inputs change during CONV.
REQ-025 The refresh counter SHALL count 0..2^REFRESH_BITS-1; on wrap, the digit index SHALL advance 0..NUM_DIGITS-1 and wrap to 0.
REQ-026 seg, dp and an SHALL be registered, one cycle behind the digit index.
REQ-027 an SHALL be all-ones except bit idx = 0 when display_en = 1; an = all-ones, seg = 7'h7F and dp = 1 when display_en = 0.
REQ-028 seg encoding (hex 0..F) SHALL be: 40,79,24,30,19,12,02,78,00,10,08,03,46,21,06,0E.
REQ-029 Leading-zero blank: digit i > 0 SHALL show seg = 7'h7F when blank_lz = 1 and digits i..NUM_DIGITS-1 are all 0; digit 0 is never blanked; dp is unaffected.
REQ-030 dp SHALL be 0 when dp_sel[idx] = 1 and display_en = 1.

Reset
REQ-031 rst SHALL immediately force: FSM = IDLE, ready = 1, display register = 0, overflow = 0, refresh counter = 0, idx = 0, an = all-ones, seg = 7'h7F, dp = 1.
REQ-032 rst during CONV SHALL abort the conversion with no display update; the first load after release is accepted normally.

Structure
REQ-033 Package seg_display_pkg SHALL hold the FSM state typedef, the 16-entry segment table, and constants SEG_BLANK = 7'h7F, HEX_F = 4'hF, BCD_9 = 4'h9.
REQ-034 The BCD converter SHALL be sub-module bin2bcd_seq: start/busy/done handshake, parameters VALUE_W and NUM_DIGITS, outputs bcd and ovf.

Verification (NUM_DIGITS=4, VALUE_W=16, REFRESH_BITS=2)
REQ-035 Hex load 16'hBEEF -> display F,E,E,B at T+1; an sequence 1110,1101,1011,0111, each held 4 cycles; digit0 seg = 0E.
REQ-036 Dec load 16'd1234 -> ready low 17 cycles; then digits 4,3,2,1 (19,30,24,79); overflow = 0.
REQ-037 Dec load 16'd10000 -> 9999, overflow = 1; then dec load 0 with blank_lz = 1 -> digits 3..1 = 7F, digit0 = 40, overflow = 0.
REQ-038 Dec load 42, then load 99 pulsed during CONV -> second load ignored; display 0042; with blank_lz = 1, digits 3..2 = 7F.
REQ-039 rst asserted at CONV cycle 8 -> outputs take reset values without a clk edge; the display never shows the aborted value.
REQ-040 display_en = 0 -> an = 1111, seg = 7F; dp_sel = 0010 with display_en = 1 -> dp = 0 only while an = 1101.

Source files
------------

// File: rtl/seg_display_pkg.sv
// Shared types and constants for the multiplexed 7-segment display controller.
package seg_display_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CONV = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [3:0] HEX_F     = 4'hF;
    localparam logic [3:0] BCD_9     = 4'h9;

    // Active-low patterns, entry 0 in the low slice (index by nibble value).
    localparam logic [15:0][6:0] SEG_TABLE = {
        7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
        7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
    };

    function automatic logic [6:0] seg_encode(input logic [3:0] nib);
        return SEG_TABLE[nib];
    endfunction

endpackage

// File: rtl/seg_display_bin2bcd_seq.sv
// Sequential shift-add-3 binary to BCD converter, one input bit per clock.
module bin2bcd_seq
    import seg_display_pkg::*;
#(
    parameter int VALUE_W    = 16,
    parameter int NUM_DIGITS = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [VALUE_W-1:0]      value_in,
    output logic                    busy,
    output logic                    done,
    output logic [4*NUM_DIGITS-1:0] bcd,
    output logic                    ovf
);

    localparam int BCD_W = 4 * NUM_DIGITS;
    localparam int CNT_W = $clog2(VALUE_W + 1);

    logic                r_busy;
    logic [CNT_W-1:0]    r_cnt;
    logic [VALUE_W-1:0]  r_bin;
    logic [BCD_W-1:0]    r_bcd;
    logic                r_ovf;
    logic [BCD_W-1:0]    w_adj;

    always_comb begin
        w_adj = r_bcd;
        for (int d = 0; d < NUM_DIGITS; d++) begin
            if (r_bcd[4*d +: 4] >= 4'd5)
                w_adj[4*d +: 4] = r_bcd[4*d +: 4] + 4'd3;
        end
    end

    // done marks the cycle whose closing edge performs the final shift
    assign done = r_busy && (r_cnt == CNT_W'(VALUE_W - 1));
    assign busy = r_busy;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_busy <= 1'b0;
            r_cnt  <= '0;
        end else if (start) begin
            r_busy <= 1'b1;
            r_cnt  <= '0;
        end else if (r_busy) begin
            r_cnt <= r_cnt + CNT_W'(1);
            if (done)
                r_busy <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (start) begin
            r_bin <= value_in;
            r_bcd <= '0;
            r_ovf <= 1'b0;
        end else if (r_busy) begin
            r_bin <= r_bin << 1;
            r_bcd <= {w_adj[BCD_W-2:0], r_bin[VALUE_W-1]};
            r_ovf <= r_ovf | w_adj[BCD_W-1];
        end
    end

    assign bcd = r_bcd;
    assign ovf = r_ovf;

endmodule

// File: rtl/seg_display_ctrl.sv
// Multiplexed 7-segment display driver with hex or sequential-BCD value capture.
module seg_display_ctrl
    import seg_display_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int VALUE_W      = 16,
    parameter int REFRESH_BITS = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [VALUE_W-1:0]    value_in,
    input  logic                  load,
    output logic                  ready,
    input  logic                  dec_mode,
    input  logic                  blank_lz,
    input  logic [NUM_DIGITS-1:0] dp_sel,
    input  logic                  display_en,
    output logic [6:0]            seg,
    output logic                  dp,
    output logic [NUM_DIGITS-1:0] an,
    output logic                  overflow
);

    localparam int DISP_W = 4 * NUM_DIGITS;
    localparam int IDX_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    function automatic logic [DISP_W-1:0] sat_fill(input logic [3:0] d);
        return {NUM_DIGITS{d}};
    endfunction

    state_t                  r_state;
    state_t                  w_next;
    logic                    w_ready;
    logic                    w_dec_upd;
    logic                    w_accept;
    logic                    w_start;
    logic                    w_conv_busy;
    logic                    w_conv_done;
    logic [DISP_W-1:0]       w_bcd;
    logic                    w_conv_ovf;
    logic [31:0]             w_ext;
    logic [DISP_W-1:0]       w_low;
    logic                    w_hi;
    logic                    r_hex_vld_p0;
    logic [DISP_W-1:0]       r_hex_val_p0;
    logic                    r_hex_ovf_p0;
    logic [DISP_W-1:0]       r_disp;
    logic                    r_ovf;
    logic [REFRESH_BITS-1:0] r_refresh;
    logic [IDX_W-1:0]        r_idx;
    logic [NUM_DIGITS-1:0]   w_zero_from;
    logic [3:0]              w_nib;
    logic                    w_blank;
    logic [6:0]              r_seg_p1;
    logic                    r_dp_p1;
    logic [NUM_DIGITS-1:0]   r_an_p1;

    assign w_accept = load && w_ready;
    assign w_start  = w_accept && dec_mode;
    assign w_ext    = 32'(value_in);
    assign w_low    = w_ext[DISP_W-1:0];
    assign w_hi     = (w_ext >> DISP_W) != 32'd0;

    bin2bcd_seq #(
        .VALUE_W    (VALUE_W),
        .NUM_DIGITS (NUM_DIGITS)
    ) u_bin2bcd (
        .clk      (clk),
        .rst      (rst),
        .start    (w_start),
        .value_in (value_in),
        .busy     (w_conv_busy),
        .done     (w_conv_done),
        .bcd      (w_bcd),
        .ovf      (w_conv_ovf)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_state <= ST_IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: if (w_start)     w_next = ST_CONV;
            ST_CONV: if (w_conv_done) w_next = ST_DONE;
            ST_DONE:                  w_next = ST_IDLE;
            default:                  w_next = ST_IDLE;
        endcase
    end

    always_comb begin
        w_ready   = (r_state == ST_IDLE) && !w_conv_busy;
        w_dec_upd = (r_state == ST_DONE);
    end

    assign ready = w_ready;

    // ---- stage p0: hex capture, applied to the display one edge later
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_hex_vld_p0 <= 1'b0;
        else
            r_hex_vld_p0 <= w_accept && !dec_mode;
    end

    always_ff @(posedge clk) begin
        if (w_accept && !dec_mode) begin
            r_hex_val_p0 <= w_low;
            r_hex_ovf_p0 <= w_hi;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_disp <= '0;
            r_ovf  <= 1'b0;
        end else if (w_dec_upd) begin
            r_disp <= w_conv_ovf ? sat_fill(BCD_9) : w_bcd;
            r_ovf  <= w_conv_ovf;
        end else if (r_hex_vld_p0) begin
            r_disp <= r_hex_ovf_p0 ? sat_fill(HEX_F) : r_hex_val_p0;
            r_ovf  <= r_hex_ovf_p0;
        end
    end

    assign overflow = r_ovf;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_refresh <= '0;
            r_idx     <= '0;
        end else begin
            r_refresh <= r_refresh + REFRESH_BITS'(1);
            if (&r_refresh)
                r_idx <= (r_idx == IDX_W'(NUM_DIGITS - 1)) ? '0 : r_idx + IDX_W'(1);
        end
    end

    // w_zero_from[i]: digits i and everything to their left are zero
    always_comb begin : lz_scan
        logic v_z;
        v_z         = 1'b1;
        w_zero_from = '0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            v_z            = v_z && (r_disp[4*i +: 4] == 4'd0);
            w_zero_from[i] = v_z;
        end
    end

    assign w_nib   = r_disp[4*int'(r_idx) +: 4];
    assign w_blank = blank_lz && (r_idx != '0) && w_zero_from[r_idx];

    // ---- stage p1: registered drive, one cycle behind the digit index
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_seg_p1 <= SEG_BLANK;
            r_dp_p1  <= 1'b1;
            r_an_p1  <= '1;
        end else if (!display_en) begin
            r_seg_p1 <= SEG_BLANK;
            r_dp_p1  <= 1'b1;
            r_an_p1  <= '1;
        end else begin
            r_seg_p1 <= w_blank ? SEG_BLANK : seg_encode(w_nib);
            r_dp_p1  <= ~dp_sel[r_idx];
            r_an_p1  <= ~(NUM_DIGITS'(1) << r_idx);
        end
    end

    assign seg = r_seg_p1;
    assign dp  = r_dp_p1;
    assign an  = r_an_p1;

endmodule
